// File: rtl/ex_wb_skid_stage_checker.sv
// Occupancy invariants of the skid stage.
module ex_wb_skid_stage_checker (
    input logic clk,
    input logic reset,
    input logic main_valid,
    input logic skid_valid,
    input logic in_ready
);
    a_skid_implies_main: assert property (@(posedge clk) disable iff (reset)
        skid_valid |-> main_valid);
    a_ready_tracks_skid: assert property (@(posedge clk) disable iff (reset)
        in_ready == !skid_valid);
endmodule

// File: rtl/ex_wb_skid_stage.sv
// ex_wb_skid_stage: EX->WB pipeline register with a valid/ready handshake and a
// two-entry skid buffer (main entry drives the outputs, skid entry absorbs the
// one result that arrives while WB is stalled). Flush kills both entries and
// zeroes their payloads. in_ready is registered and never depends
// combinationally on out_ready.
// Optional feature macro: EX_WB_STALL_CNT_EN adds a saturating stall counter
// (stall_cnt, CNT_WIDTH bits) counting cycles with out_valid & ~out_ready.
module ex_wb_skid_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     alu_output_in,
    input  logic [ADDR_WIDTH-1:0]     ram_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr_wr_in,
    input  logic                      wr_reg_in,
    input  logic                      mem_to_reg_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     alu_output_out,
    output logic [ADDR_WIDTH-1:0]     ram_addr_out,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr_wr_out,
    output logic                      wr_reg_out,
    output logic                      mem_to_reg_out
`ifdef EX_WB_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      stall_cnt
`endif
);

    // Packed payload: {alu, ram_addr, reg_addr, wr_reg, mem_to_reg}
    localparam int PW = DATA_WIDTH + ADDR_WIDTH + REG_ADDR_WIDTH + 2;

    logic [PW-1:0] main_payload_r, skid_payload_r, in_payload_s;
    logic [PW-1:0] main_payload_next_s, skid_payload_next_s;
    logic          main_valid_r, skid_valid_r, in_ready_r;
    logic          main_valid_next_s, skid_valid_next_s;
    logic          accept_s, pop_s;

    assign in_payload_s = {alu_output_in, ram_addr_in, reg_addr_wr_in, wr_reg_in, mem_to_reg_in};
    assign accept_s     = in_valid & in_ready_r;
    assign pop_s        = main_valid_r & out_ready;

    // Next-state selection for main and skid entries, flush taking priority.
    always_comb begin
        main_valid_next_s   = main_valid_r;
        skid_valid_next_s   = skid_valid_r;
        main_payload_next_s = main_payload_r;
        skid_payload_next_s = skid_payload_r;
        if (flush) begin
            main_valid_next_s   = 1'b0;
            skid_valid_next_s   = 1'b0;
            main_payload_next_s = {PW{1'b0}};
            skid_payload_next_s = {PW{1'b0}};
        end else if (!main_valid_r || pop_s) begin
            if (skid_valid_r) begin
                // Skid is older than anything arriving now, so it goes first.
                main_valid_next_s   = 1'b1;
                main_payload_next_s = skid_payload_r;
                skid_valid_next_s   = accept_s;
                if (accept_s) begin
                    skid_payload_next_s = in_payload_s;
                end else begin
                    skid_payload_next_s = skid_payload_r;
                end
            end else if (accept_s) begin
                main_valid_next_s   = 1'b1;
                main_payload_next_s = in_payload_s;
            end else begin
                main_valid_next_s   = 1'b0;
            end
        end else if (accept_s) begin
            skid_valid_next_s   = 1'b1;
            skid_payload_next_s = in_payload_s;
        end else begin
            skid_valid_next_s   = skid_valid_r;
        end
    end

    // State registers; in_ready is registered from the next skid occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_r   <= 1'b0;
            skid_valid_r   <= 1'b0;
            main_payload_r <= {PW{1'b0}};
            skid_payload_r <= {PW{1'b0}};
            in_ready_r     <= 1'b1;
        end else begin
            main_valid_r   <= main_valid_next_s;
            skid_valid_r   <= skid_valid_next_s;
            main_payload_r <= main_payload_next_s;
            skid_payload_r <= skid_payload_next_s;
            in_ready_r     <= ~skid_valid_next_s;
        end
    end

    assign in_ready        = in_ready_r;
    assign out_valid       = main_valid_r;
    assign alu_output_out  = main_payload_r[PW-1 -: DATA_WIDTH];
    assign ram_addr_out    = main_payload_r[REG_ADDR_WIDTH+2 +: ADDR_WIDTH];
    assign reg_addr_wr_out = main_payload_r[2 +: REG_ADDR_WIDTH];
    assign wr_reg_out      = main_payload_r[1] & main_valid_r;
    assign mem_to_reg_out  = main_payload_r[0] & main_valid_r;

`ifdef EX_WB_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_r;

    // Saturating count of cycles WB holds off a valid result; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (main_valid_r && !out_ready && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    ex_wb_skid_stage_checker u_checker (
        .clk        (clk),
        .reset      (reset),
        .main_valid (main_valid_r),
        .skid_valid (skid_valid_r),
        .in_ready   (in_ready_r)
    );

endmodule

// File: tb/tb_ex_wb_skid_stage.sv
// Self-checking bench for ex_wb_skid_stage: a two-deep FIFO model is compared
// against the DUT on every cycle, plus directed literal expectations.
module tb_ex_wb_skid_stage;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RW = 5;
    localparam int CW = 4;
`ifdef EX_WB_STALL_CNT_EN
    int cnt_m;
    logic [CW-1:0] stall_cnt;
`endif

    typedef struct packed {
        logic [DW-1:0] alu;
        logic [AW-1:0] ram;
        logic [RW-1:0] rg;
        logic          wr;
        logic          m2r;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic          wr_reg_in, mem_to_reg_in, wr_reg_out, mem_to_reg_out;
    logic [DW-1:0] alu_output_in, alu_output_out;
    logic [AW-1:0] ram_addr_in, ram_addr_out;
    logic [RW-1:0] reg_addr_wr_in, reg_addr_wr_out;

    ent_t          q[$];
    logic [DW-1:0] log_q[$];
    bit            zeroed;
    bit            last_acc;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    ex_wb_skid_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .alu_output_in   (alu_output_in),
        .ram_addr_in     (ram_addr_in),
        .reg_addr_wr_in  (reg_addr_wr_in),
        .wr_reg_in       (wr_reg_in),
        .mem_to_reg_in   (mem_to_reg_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .alu_output_out  (alu_output_out),
        .ram_addr_out    (ram_addr_out),
        .reg_addr_wr_out (reg_addr_wr_out),
        .wr_reg_out      (wr_reg_out),
        .mem_to_reg_out  (mem_to_reg_out)
`ifdef EX_WB_STALL_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of capacity 2; in_ready means fewer than 2 held.
    task automatic model_update();
        bit acc;
        bit pop;
        ent_t e;
        last_acc = 1'b0;
        if (reset) begin
            q.delete();
            zeroed = 1'b1;
`ifdef EX_WB_STALL_CNT_EN
            cnt_m = 0;
`endif
        end else begin
`ifdef EX_WB_STALL_CNT_EN
            if (q.size() > 0 && !out_ready && cnt_m < (1 << CW) - 1) cnt_m++;
`endif
            if (flush) begin
                q.delete();
                zeroed = 1'b1;
            end else begin
                acc = in_valid && (q.size() < 2);
                pop = (q.size() > 0) && out_ready;
                if (pop) begin
                    log_q.push_back(q[0].alu);
                    void'(q.pop_front());
                end
                if (acc) begin
                    e = '{alu_output_in, ram_addr_in, reg_addr_wr_in, wr_reg_in, mem_to_reg_in};
                    q.push_back(e);
                end
                last_acc = acc;
                if (q.size() > 0) zeroed = 1'b0;
            end
        end
    endtask

    task automatic drive(input bit iv, input logic [DW-1:0] a, input logic [RW-1:0] r,
                         input bit w, input bit m, input bit ordy);
        in_valid       = iv;
        alu_output_in  = a;
        ram_addr_in    = a[AW-1:0] ^ 8'h5A;
        reg_addr_wr_in = r;
        wr_reg_in      = w;
        mem_to_reg_in  = m;
        out_ready      = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Per-cycle comparison of DUT outputs against the FIFO model.
    always @(negedge clk) begin
        chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
        chk("out_valid", {63'd0, out_valid}, {63'd0, (q.size() > 0)});
        if (q.size() > 0) begin
            chk("alu_out", {32'd0, alu_output_out}, {32'd0, q[0].alu});
            chk("ram_out", {56'd0, ram_addr_out}, {56'd0, q[0].ram});
            chk("reg_out", {59'd0, reg_addr_wr_out}, {59'd0, q[0].rg});
            chk("wr_reg_out", {63'd0, wr_reg_out}, {63'd0, q[0].wr});
            chk("m2r_out", {63'd0, mem_to_reg_out}, {63'd0, q[0].m2r});
        end else begin
            chk("wr_reg_empty", {63'd0, wr_reg_out}, 64'd0);
            chk("m2r_empty", {63'd0, mem_to_reg_out}, 64'd0);
            if (zeroed) begin
                chk("alu_zero", {32'd0, alu_output_out}, 64'd0);
                chk("ram_zero", {56'd0, ram_addr_out}, 64'd0);
                chk("reg_zero", {59'd0, reg_addr_wr_out}, 64'd0);
            end
        end
`ifdef EX_WB_STALL_CNT_EN
        chk("stall_cnt", {60'd0, stall_cnt}, cnt_m[63:0]);
`endif
    end

    initial begin
        int hits;
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_alu", {32'd0, alu_output_out}, 64'd0);
        reset = 1'b0;

        // Single result, unstalled: visible one cycle after accept.
        drive(1'b1, 32'h0000_00AA, 5'd5, 1'b1, 1'b0, 1'b1);
        tick();
        chk("t1_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_alu", {32'd0, alu_output_out}, 64'h0000_00AA);
        chk("t1_reg", {59'd0, reg_addr_wr_out}, 64'd5);
        chk("t1_wr", {63'd0, wr_reg_out}, 64'd1);
        chk("t1_ready", {63'd0, in_ready}, 64'd1);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();

        // Stalled stream 0x10, 0x11, 0x12 then drain.
        log_q.delete();
        drive(1'b1, 32'h10, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h11, 5'd2, 1'b1, 1'b1, 1'b0);
        tick();
        chk("t2_full_ready", {63'd0, in_ready}, 64'd0);
        chk("t2_full_alu", {32'd0, alu_output_out}, 64'h10);
        drive(1'b1, 32'h12, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        chk("t2_held_alu", {32'd0, alu_output_out}, 64'h10);
        drive(1'b1, 32'h12, 5'd3, 1'b1, 1'b0, 1'b1);
        tick();
        chk("t2_drain1", {32'd0, alu_output_out}, 64'h11);
        chk("t2_drain1_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("t2_drain2", {32'd0, alu_output_out}, 64'h12);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("t2_empty", {63'd0, out_valid}, 64'd0);
        chk("t2_log_n", log_q.size(), 64'd3);
        chk("t2_log0", {32'd0, log_q[0]}, 64'h10);
        chk("t2_log1", {32'd0, log_q[1]}, 64'h11);
        chk("t2_log2", {32'd0, log_q[2]}, 64'h12);

        // Flush with both entries full and a pending input.
        drive(1'b1, 32'h20, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h21, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h55, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        flush = 1'b0;
        chk("t3_valid", {63'd0, out_valid}, 64'd0);
        chk("t3_alu", {32'd0, alu_output_out}, 64'd0);
        chk("t3_ram", {56'd0, ram_addr_out}, 64'd0);
        chk("t3_reg", {59'd0, reg_addr_wr_out}, 64'd0);
        chk("t3_ready", {63'd0, in_ready}, 64'd1);
        // Flush while in_ready=1: the same-cycle accept must be discarded.
        drive(1'b1, 32'h30, 5'd8, 1'b0, 1'b0, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h56, 5'd9, 1'b1, 1'b0, 1'b1);
        tick();
        flush = 1'b0;
        chk("t3b_valid", {63'd0, out_valid}, 64'd0);
        chk("t3b_alu", {32'd0, alu_output_out}, 64'd0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        hits = 0;
        foreach (log_q[i]) if (log_q[i] == 32'h55 || log_q[i] == 32'h56) hits++;
        chk("t3_flushed_never_out", hits, 64'd0);

        // Reset while the skid is full.
        drive(1'b1, 32'h40, 5'd10, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h41, 5'd11, 1'b1, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_alu", {32'd0, alu_output_out}, 64'd0);
        chk("t5_wr", {63'd0, wr_reg_out}, 64'd0);
        chk("t5_ready", {63'd0, in_ready}, 64'd1);
`ifdef EX_WB_STALL_CNT_EN
        chk("t5_stall_cnt", {60'd0, stall_cnt}, 64'd0);
`endif

        // Hold one entry stalled for 20 cycles, then flush.
        drive(1'b1, 32'h50, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (20) tick();
        chk("t6_held_alu", {32'd0, alu_output_out}, 64'h50);
`ifdef EX_WB_STALL_CNT_EN
        chk("t6_sat", {60'd0, stall_cnt}, 64'd15);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_flush_valid", {63'd0, out_valid}, 64'd0);
`ifdef EX_WB_STALL_CNT_EN
        chk("t6_sat_after_flush", {60'd0, stall_cnt}, 64'd15);
`endif

        // Random traffic; source holds its payload until accepted.
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 2000; i++) begin
            if (!(in_valid && !last_acc)) begin
                drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), out_ready);
            end
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 63) == 0);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        chk("final_empty", {63'd0, out_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_wb_skid_stage.md
Name: ex_wb_skid_stage

Overview:
- Parametrised successor to the EX→WB pipeline register.
- Adds a valid/ready handshake and a 2-entry skid buffer, so writeback back-pressure (multi-cycle RAM, port conflicts) stalls EX without dropping results.
- Keeps flush with zeroing semantics.
- Sits between the EX stage/ALU and the WB mux/register-file write port of the state-machine MIPS.

Parameters:
- DATA_WIDTH, 32, width of ALU result.
- ADDR_WIDTH, 8, width of data-RAM address.
- REG_ADDR_WIDTH, 5, width of destination register address.
- CNT_WIDTH, 16, width of stall counter (optional feature only).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  synchronous; kill all in-flight entries.
- in_valid  input  1  EX presents a result.
- in_ready  output  1  stage can accept; registered.
- alu_output_in  input  DATA_WIDTH  ALU result.
- ram_addr_in  input  ADDR_WIDTH  data-RAM address.
- reg_addr_wr_in  input  REG_ADDR_WIDTH  destination register.
- wr_reg_in  input  1  register-write enable.
- mem_to_reg_in  input  1  WB selects RAM data.
- out_valid  output  1  output payload valid.
- out_ready  input  1  WB consumes this cycle.
- alu_output_out  output  DATA_WIDTH  registered payload.
- ram_addr_out  output  ADDR_WIDTH  registered payload.
- reg_addr_wr_out  output  REG_ADDR_WIDTH  registered payload.
- wr_reg_out  output  1  qualified: main_wr_reg AND out_valid.
- mem_to_reg_out  output  1  qualified: main_mem_to_reg AND out_valid.
- stall_cnt  output  CNT_WIDTH  present only with EX_WB_STALL_CNT_EN.

Behaviour:
- State: main entry (drives outputs) and skid entry; each holds a payload and a valid bit.
- Reset (clk, reset synchronous active-high):
  - Both valid bits = 0, all payloads = 0.
  - in_ready = 1, out_valid = 0, all outputs = 0, stall_cnt = 0.
- accept = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready is registered as ~skid_valid_next. It is never a combinational path from out_ready.
- Per-cycle rules, in priority order:
  1. reset: as above.
  2. flush: both valid = 0, both payloads = 0, in_ready = 1. A same-cycle accept is discarded and a same-cycle pop is ignored; flush wins.
  3. main empty, or pop: main loads from skid if skid valid (skid then empties), else from input on accept, else main becomes empty.
  4. main full, no pop, accept: input loads into skid.
- Invariant: skid valid implies main valid. An assertion checks it.
- Ordering: strictly FIFO. Skid data always precedes same-cycle input data.
- Latency: 1 cycle from accept to out_valid when unstalled. Throughput is 1 result per cycle with out_ready held at 1.
- Full (skid valid):
  - in_ready = 0 the next cycle.
  - in_valid with in_ready = 0 has no effect; EX must hold its payload.
- Empty: out_valid = 0. wr_reg_out and mem_to_reg_out read 0 regardless of stale payload.
- Flush or reset mid-stall clears both entries in one cycle. No partial drain.
- Payload bits are not required to hold stable while out_valid = 0, except they must be 0 after reset or flush.

Optional Feature:
- Macro: EX_WB_STALL_CNT_EN.
- Defined:
  - stall_cnt counts cycles with out_valid & ~out_ready.
  - Saturates at all-ones; no wrap.
  - Cleared by reset only; flush does not clear it.
- Undefined: stall_cnt port and counter logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then in_valid = 1 with alu = 0x0000_00AA, reg = 5, wr_reg = 1, out_ready = 1 → next cycle out_valid = 1, alu_output_out = 0xAA, reg_addr_wr_out = 5, wr_reg_out = 1; in_ready stays 1.
- Stream 0x10, 0x11, 0x12 back-to-back with out_ready = 0 → 0x10 in main, 0x11 in skid, in_ready = 0; 0x12 held by source. Raise out_ready → outputs 0x10, 0x11, 0x12 on consecutive cycles with no loss or duplication.
- Main and skid full, assert flush with in_valid = 1 (alu = 0x55) → next cycle out_valid = 0, all outputs 0, in_ready = 1; 0x55 never appears.
- Random in_valid/out_ready (50%), 2000 cycles, scoreboard → output sequence equals accepted sequence; wr_reg_out = 0 whenever out_valid = 0; invariant never violated.
- Reset asserted while skid full → next cycle all outputs 0, in_ready = 1. With EX_WB_STALL_CNT_EN defined, stall_cnt = 0.
- EX_WB_STALL_CNT_EN, CNT_WIDTH = 4: hold one entry with out_ready = 0 for 20 cycles → stall_cnt saturates at 15, then holds at 15 after a flush.
